// File: rtl/main_fsm_if.sv
// Control-sequencer bus: instruction fields in, per-cycle datapath controls out.
interface main_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic       Illegal;

  // Sequencer side: reads the instruction fields, drives the controls.
  modport master (
    input  Op, Funct,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp, Illegal
  );

  // Datapath/decoder side: supplies the instruction fields, consumes the controls.
  modport slave (
    output Op, Funct,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp, Illegal
  );
endinterface

// File: rtl/main_fsm.sv
// Multicycle Moore control sequencer for the ARM-subset CPU. Fetch, decode,
// execute, memory and writeback share one memory and one ALU across cycles;
// every control output is a pure function of the current state.
module main_fsm (
  input  logic        clk,
  input  logic        reset,
  main_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXECUTER = 4'd2,
    S_EXECUTEI = 4'd3,
    S_ALUWB    = 4'd4,
    S_MEMADR   = 4'd5,
    S_MEMRD    = 4'd6,
    S_MEMWB    = 4'd7,
    S_MEMWR    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ILLEGAL  = 4'd10
  } state_e;

  state_e state_q, state_d;

  // State register; reset forces FETCH immediately, without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; Op/Funct only matter in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_MEMADR:   state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_FETCH;
      // Unused encodings recover to FETCH.
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode; anything not set for a state (and all of an unused encoding) is 0.
  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.ALUOp     = 1'b0;
    bus.Illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.NextPC    = 1'b1;
      end
      S_DECODE: begin
        // PC+8 is computed here so branches can use it as the base.
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_EXECUTER: begin
        bus.ALUOp     = 1'b1;
      end
      S_EXECUTEI: begin
        bus.ALUSrcB   = 2'b01;
        bus.ALUOp     = 1'b1;
      end
      S_ALUWB: begin
        bus.RegW      = 1'b1;
      end
      S_MEMADR: begin
        bus.ALUSrcB   = 2'b01;
      end
      S_MEMRD: begin
        bus.AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
      end
      S_MEMWR: begin
        bus.AdrSrc    = 1'b1;
        bus.MemW      = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.Branch    = 1'b1;
      end
      S_ILLEGAL: begin
        // Instruction is dropped; the PC already advanced in FETCH.
        bus.Illegal   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_fsm.sv
module tb_main_fsm;

  // Output vector layout:
  // {IRWrite, AdrSrc, ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], NextPC, RegW, MemW, Branch, ALUOp, Illegal}
  localparam logic [13:0] V_FET = 14'b1_0_01_10_10_1_0_0_0_0_0;
  localparam logic [13:0] V_DEC = 14'b0_0_01_10_10_0_0_0_0_0_0;
  localparam logic [13:0] V_EXR = 14'b0_0_00_00_00_0_0_0_0_1_0;
  localparam logic [13:0] V_EXI = 14'b0_0_00_01_00_0_0_0_0_1_0;
  localparam logic [13:0] V_AWB = 14'b0_0_00_00_00_0_1_0_0_0_0;
  localparam logic [13:0] V_MAD = 14'b0_0_00_01_00_0_0_0_0_0_0;
  localparam logic [13:0] V_MRD = 14'b0_1_00_00_00_0_0_0_0_0_0;
  localparam logic [13:0] V_MWB = 14'b0_0_00_00_01_0_1_0_0_0_0;
  localparam logic [13:0] V_MWR = 14'b0_1_00_00_00_0_0_1_0_0_0;
  localparam logic [13:0] V_BR  = 14'b0_0_00_01_10_0_0_0_1_0_0;
  localparam logic [13:0] V_ILL = 14'b0_0_00_00_00_0_0_0_0_0_1;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  main_fsm_if bus ();

  main_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] outs();
    return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.ALUOp, bus.Illegal};
  endfunction

  task automatic drive(input logic [1:0] op, input logic [5:0] funct);
    bus.Op    = op;
    bus.Funct = funct;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    drive(2'b11, 6'b000000);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    got = outs();
    n_vec++;
    if (got !== V_FET) begin
      n_miss++;
      $display("FAIL reset_async: got %b expected %b", got, V_FET);
    end
    // Hold reset across two edges; outputs stay at FETCH.
    repeat (2) @(posedge clk);
    #1;
    got = outs();
    n_vec++;
    if (got !== V_FET) begin
      n_miss++;
      $display("FAIL reset_held: got %b expected %b", got, V_FET);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    got = outs();
    n_vec++;
    if (got !== V_FET) begin
      n_miss++;
      $display("FAIL reset_release: got %b expected %b", got, V_FET);
    end
  endtask

  task automatic test_addi();
    logic [13:0] exp [4];
    logic [13:0] got;
    exp = '{V_DEC, V_EXI, V_AWB, V_FET};
    drive(2'b00, 6'b101000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      got = outs();
      n_vec++;
      if (got !== exp[i]) begin
        n_miss++;
        $display("FAIL addi step %0d: got %b expected %b", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_add_reg();
    logic [13:0] exp [4];
    logic [13:0] got;
    exp = '{V_DEC, V_EXR, V_AWB, V_FET};
    drive(2'b00, 6'b001000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      got = outs();
      n_vec++;
      if (got !== exp[i]) begin
        n_miss++;
        $display("FAIL add_reg step %0d: got %b expected %b", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_ldr();
    logic [13:0] exp [5];
    logic [13:0] got;
    exp = '{V_DEC, V_MAD, V_MRD, V_MWB, V_FET};
    drive(2'b01, 6'b011001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      got = outs();
      n_vec++;
      if (got !== exp[i]) begin
        n_miss++;
        $display("FAIL ldr step %0d: got %b expected %b", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_str();
    logic [13:0] exp [4];
    logic [13:0] got;
    int memw_cnt;
    int regw_cnt;
    exp = '{V_DEC, V_MAD, V_MWR, V_FET};
    memw_cnt = 0;
    regw_cnt = 0;
    drive(2'b01, 6'b011000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      got = outs();
      memw_cnt += int'(bus.MemW);
      regw_cnt += int'(bus.RegW);
      n_vec++;
      if (got !== exp[i]) begin
        n_miss++;
        $display("FAIL str step %0d: got %b expected %b", i, got, exp[i]);
      end
    end
    n_vec++;
    if (memw_cnt != 1 || regw_cnt != 0) begin
      n_miss++;
      $display("FAIL str_pulses: got MemW=%0d RegW=%0d cycles expected 1 and 0", memw_cnt, regw_cnt);
    end
  endtask

  task automatic test_branch();
    logic [13:0] exp [3];
    logic [13:0] got;
    exp = '{V_DEC, V_BR, V_FET};
    drive(2'b10, 6'b000000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      got = outs();
      n_vec++;
      if (got !== exp[i]) begin
        n_miss++;
        $display("FAIL branch step %0d: got %b expected %b", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [13:0] exp [3];
    logic [13:0] got;
    int ill_cnt;
    exp = '{V_DEC, V_ILL, V_FET};
    ill_cnt = 0;
    drive(2'b11, 6'b111111);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      got = outs();
      ill_cnt += int'(bus.Illegal);
      n_vec++;
      if (got !== exp[i]) begin
        n_miss++;
        $display("FAIL illegal step %0d: got %b expected %b", i, got, exp[i]);
      end
    end
    n_vec++;
    if (ill_cnt != 1) begin
      n_miss++;
      $display("FAIL illegal_pulse: got %0d cycles expected 1", ill_cnt);
    end
  endtask

  // Back-to-back instructions, with the fields changing only during FETCH.
  task automatic test_back_to_back();
    logic [13:0] exp [6];
    logic [13:0] got;
    exp = '{V_DEC, V_BR, V_FET, V_DEC, V_MAD, V_MRD};
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(2'b10, 6'b000001);
      if (i == 3) drive(2'b01, 6'b000001);
      @(posedge clk);
      #1;
      got = outs();
      n_vec++;
      if (got !== exp[i]) begin
        n_miss++;
        $display("FAIL b2b step %0d: got %b expected %b", i, got, exp[i]);
      end
      // Fields changed outside DECODE must be ignored: flip Funct[0] in MEMADR? no, only after MEMRD.
    end
    // Finish the LDR: MEMWB then FETCH.
    drive(2'b11, 6'b000000);
    @(posedge clk);
    #1;
    got = outs();
    n_vec++;
    if (got !== V_MWB) begin
      n_miss++;
      $display("FAIL b2b_memwb: got %b expected %b", got, V_MWB);
    end
    @(posedge clk);
    #1;
    got = outs();
    n_vec++;
    if (got !== V_FET) begin
      n_miss++;
      $display("FAIL b2b_fetch: got %b expected %b", got, V_FET);
    end
  endtask

  task automatic test_reset_mid_memwr();
    logic [13:0] exp [3];
    logic [13:0] got;
    exp = '{V_DEC, V_MAD, V_MWR};
    drive(2'b01, 6'b011000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      got = outs();
      n_vec++;
      if (got !== exp[i]) begin
        n_miss++;
        $display("FAIL rst_memwr step %0d: got %b expected %b", i, got, exp[i]);
      end
    end
    // Now 1 time unit after the edge into MEMWR; next edge is 4 units away.
    #1;
    reset = 1'b1;
    #1;
    got = outs();
    n_vec++;
    if (bus.MemW !== 1'b0 || got !== V_FET) begin
      n_miss++;
      $display("FAIL rst_memwr_abort: got %b expected %b", got, V_FET);
    end
    @(posedge clk);
    #1;
    got = outs();
    n_vec++;
    if (bus.IRWrite !== 1'b1 || got !== V_FET) begin
      n_miss++;
      $display("FAIL rst_memwr_hold: got %b expected %b", got, V_FET);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    got = outs();
    n_vec++;
    if (got !== V_DEC) begin
      n_miss++;
      $display("FAIL rst_memwr_decode: got %b expected %b", got, V_DEC);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b0;
    drive(2'b00, 6'b000000);
    test_reset();
    test_addi();
    test_add_reg();
    test_ldr();
    test_str();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_reset_mid_memwr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
